// File: rtl/debounce_array.sv
// Multi-channel button debouncer with press/release/long-press pulses on a shared sampling tick.
// Define DEBOUNCE_ARRAY_REPEAT_EN for auto-repeat; release/repeat are reserved words, so those ports are release_p/repeat_p.
module debounce_array #(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned TICK_DIV     = 10000,
    parameter int unsigned DB_TICKS     = 20,
    parameter int unsigned LONG_TICKS   = 1000,
    parameter int unsigned REPEAT_TICKS = 200,
    parameter int unsigned ACTIVE_LOW   = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] in,
    output logic [N_CH-1:0] state,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] release_p,
    output logic [N_CH-1:0] long_press,
    output logic [N_CH-1:0] repeat_p
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int MW = (DB_TICKS > 1) ? $clog2(DB_TICKS) : 1;
    localparam int HW = $clog2(LONG_TICKS + 1);

    localparam logic [PW-1:0] DIV_LAST  = PW'(TICK_DIV - 1);
    localparam logic [MW-1:0] DB_LAST   = MW'(DB_TICKS - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_TICKS);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);

    logic [PW-1:0]   div_q, div_d;
    logic            tick_s;
    logic [N_CH-1:0] in_s;
    logic [N_CH-1:0] meta_q, sync_q;
    logic [N_CH-1:0] state_q, state_d;
    logic [N_CH-1:0] prev_q;
    logic [N_CH-1:0] press_q, press_d;
    logic [N_CH-1:0] rel_q, rel_d;
    logic [N_CH-1:0] long_q, long_d;
    logic [MW-1:0]   mcnt_q [N_CH];
    logic [MW-1:0]   mcnt_d [N_CH];
    logic [HW-1:0]   hold_q [N_CH];
    logic [HW-1:0]   hold_d [N_CH];

    assign in_s = (ACTIVE_LOW != 0) ? ~in : in;

    // Prescaler: tick is high during the last count, so the wrap edge is the sampling edge.
    always_comb begin
        tick_s = (div_q == DIV_LAST);
        if (tick_s) begin
            div_d = '0;
        end else begin
            div_d = div_q + PW'(1);
        end
    end

    // Per-channel mismatch qualification, hold counting and edge/long-press pulse generation.
    always_comb begin
        state_d = state_q;
        long_d  = '0;
        for (int i = 0; i < N_CH; i++) begin
            mcnt_d[i] = mcnt_q[i];
            hold_d[i] = hold_q[i];
            if (sync_q[i] == state_q[i]) begin
                mcnt_d[i] = '0;
            end else if (tick_s) begin
                if (mcnt_q[i] == DB_LAST) begin
                    mcnt_d[i]  = '0;
                    state_d[i] = sync_q[i];
                end else begin
                    mcnt_d[i] = mcnt_q[i] + MW'(1);
                end
            end else begin
                mcnt_d[i] = mcnt_q[i];
            end

            if (!state_q[i]) begin
                hold_d[i] = '0;
            end else if (tick_s && (hold_q[i] != HOLD_MAX)) begin
                hold_d[i] = hold_q[i] + HW'(1);
                long_d[i] = (hold_q[i] == HOLD_LAST);
            end else begin
                hold_d[i] = hold_q[i];
            end
        end
        // prev_q lags state_q by one cycle, so pulses land the cycle after the level changes
        press_d = state_q & ~prev_q;
        rel_d   = ~state_q & prev_q;
    end

    // Channel state, synchronisers and pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            meta_q  <= '0;
            sync_q  <= '0;
            state_q <= '0;
            prev_q  <= '0;
            press_q <= '0;
            rel_q   <= '0;
            long_q  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                mcnt_q[i] <= '0;
                hold_q[i] <= '0;
            end
        end else begin
            div_q   <= div_d;
            meta_q  <= in_s;
            sync_q  <= meta_q;
            state_q <= state_d;
            prev_q  <= state_q;
            press_q <= press_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
            for (int i = 0; i < N_CH; i++) begin
                mcnt_q[i] <= mcnt_d[i];
                hold_q[i] <= hold_d[i];
            end
        end
    end

    assign state      = state_q;
    assign press      = press_q;
    assign release_p  = rel_q;
    assign long_press = long_q;

`ifdef DEBOUNCE_ARRAY_REPEAT_EN
    localparam int RW = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
    localparam logic [RW-1:0] RPT_LAST = RW'(REPEAT_TICKS - 1);

    logic [RW-1:0]   rcnt_q [N_CH];
    logic [RW-1:0]   rcnt_d [N_CH];
    logic [N_CH-1:0] rpt_q, rpt_d;

    // Auto-repeat runs only once the hold counter has saturated at the long-press point.
    always_comb begin
        rpt_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            rcnt_d[i] = rcnt_q[i];
            if (!state_q[i]) begin
                rcnt_d[i] = '0;
            end else if (tick_s && (hold_q[i] == HOLD_MAX)) begin
                if (rcnt_q[i] == RPT_LAST) begin
                    rcnt_d[i] = '0;
                    rpt_d[i]  = 1'b1;
                end else begin
                    rcnt_d[i] = rcnt_q[i] + RW'(1);
                end
            end else begin
                rcnt_d[i] = rcnt_q[i];
            end
        end
    end

    // Repeat counters and pulse register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rpt_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                rcnt_q[i] <= '0;
            end
        end else begin
            rpt_q <= rpt_d;
            for (int i = 0; i < N_CH; i++) begin
                rcnt_q[i] <= rcnt_d[i];
            end
        end
    end

    assign repeat_p = rpt_q;
`else
    // REPEAT_TICKS only shapes the enabled build; the term below folds to constant zero.
    assign repeat_p = {N_CH{1'b0 & (REPEAT_TICKS > 0)}};
`endif

endmodule
